sram_block_ctrl: RTL

- Parametrised, clocked successor to the SRAM block decoder.
- Splits the SRAM window into 2^BLOCK_BITS equal blocks using the top BLOCK_BITS lines of the SRAM address. It registers a one-hot block select for the whole 68k bus cycle.
- Generates Dtack_L after a programmable number of wait states.
- An access to a block masked off by BlockEnable_H gets Berr_L instead of Dtack_L.
- Sits between the top-level address decoder and the SRAM block chip-enables.

---
 rtl/sram_block_ctrl_if.sv | 39 +++
 rtl/sram_block_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sram_block_ctrl_if.sv
// SRAM block controller bus bundle.
// Master drives 68k-side request lines; slave returns selects and acks.
interface sram_block_ctrl_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int BLOCK_BITS = 2
);
  localparam int NUM_BLOCKS = 1 << BLOCK_BITS;

  logic [ADDR_WIDTH-1:0] Address;
  logic                  SRamSelect_H;
  logic                  AS_L;
  logic [NUM_BLOCKS-1:0] BlockEnable_H;
  logic [NUM_BLOCKS-1:0] BlockSel_H;
  logic                  Dtack_L;
  logic                  Berr_L;
  logic                  Busy_H;

  modport master (
    output Address,
    output SRamSelect_H,
    output AS_L,
    output BlockEnable_H,
    input  BlockSel_H,
    input  Dtack_L,
    input  Berr_L,
    input  Busy_H
  );

  modport slave (
    input  Address,
    input  SRamSelect_H,
    input  AS_L,
    input  BlockEnable_H,
    output BlockSel_H,
    output Dtack_L,
    output Berr_L,
    output Busy_H
  );
endinterface

// File: rtl/sram_block_ctrl.sv
// Clocked SRAM block decoder: registered one-hot block select,
// wait-state Dtack_L generation and Berr_L for masked blocks.
module sram_block_ctrl #(
  parameter  int ADDR_WIDTH  = 17,
  parameter  int BLOCK_BITS  = 2,
  parameter  int WAIT_STATES = 2,
  localparam int NUM_BLOCKS  = 1 << BLOCK_BITS
) (
  input logic              Clk,
  input logic              Reset_L,
  sram_block_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic [NUM_BLOCKS-1:0] sel_q;
  logic [NUM_BLOCKS-1:0] sel_d;
  logic                  dtack_q;
  logic                  dtack_d;
  logic                  berr_q;
  logic                  berr_d;

  logic [BLOCK_BITS-1:0] idx;
  logic                  start;
  logic                  hit;
  logic                  as_hi;
  logic                  unused_addr;

  // Block index comes from the top address lines; only IDLE looks at it.
  assign idx   = bus.Address[ADDR_WIDTH-1 -: BLOCK_BITS];
  assign start = bus.SRamSelect_H & ~bus.AS_L;
  assign hit   = bus.BlockEnable_H[idx];
  assign as_hi = bus.AS_L;

  assign unused_addr =
    ^bus.Address[ADDR_WIDTH-BLOCK_BITS-1:0];

  // State register.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: AS_L high always ends the cycle, even at counter zero.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = hit ? S_WAIT : S_ERR;
        end
      end
      S_WAIT: begin
        if (as_hi) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (as_hi) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (as_hi) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    sel_d   = sel_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        sel_d   = '0;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        cnt_d   = 4'd0;
        if (start) begin
          if (hit) begin
            sel_d = NUM_BLOCKS'(1) << idx;
            cnt_d = 4'(WAIT_STATES);
          end else begin
            berr_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (as_hi) begin
          sel_d   = '0;
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          dtack_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (as_hi) begin
          sel_d   = '0;
          dtack_d = 1'b1;
          berr_d  = 1'b1;
        end
        cnt_d = 4'd0;
      end
      S_ERR: begin
        sel_d   = '0;
        dtack_d = 1'b1;
        if (as_hi) begin
          berr_d = 1'b1;
        end
        cnt_d = 4'd0;
      end
      default: begin
        sel_d   = '0;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      sel_q   <= '0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      sel_q   <= sel_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.BlockSel_H = sel_q;
  assign bus.Dtack_L    = dtack_q;
  assign bus.Berr_L     = berr_q;
  assign bus.Busy_H     = (state_q != S_IDLE);

  // Dtack_L and Berr_L are mutually exclusive.
  a_excl: assert property (
    @(posedge Clk) disable iff (!Reset_L)
    !(!dtack_q && !berr_q)
  );

  // Block select never has more than one bit set.
  a_onehot: assert property (
    @(posedge Clk) disable iff (!Reset_L)
    $onehot0(sel_q)
  );

endmodule
